// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with ALU decode, operand forwarding and load-use detection
module ex_operand_stage #(
    parameter int FWD_EN = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic [4:0]  id_shamt,
    input  logic [5:0]  id_funct,
    input  logic [1:0]  id_alu_op,
    input  logic        id_alu_src,
    input  logic        id_reg_dst,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_control,
    output logic [4:0]  alu_shamt,
    output logic        ex_valid,
    output logic [4:0]  ex_dest,
    output logic [31:0] ex_store_data,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic        hazard_stall
);

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;

    // ID/EX register contents
    logic        valid_q;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic [31:0] rs_data_q;
    logic [31:0] rt_data_q;
    logic [31:0] imm_q;
    logic [4:0]  shamt_q;
    logic [3:0]  alu_ctrl_q;
    logic        alu_src_q;
    logic [4:0]  dest_q;
    logic        reg_write_q;
    logic        mem_read_q;
    logic        mem_write_q;
    logic        mem_to_reg_q;

    logic [3:0]  alu_ctrl_d;
    logic [4:0]  dest_d;
    logic [31:0] fwd_rs;
    logic [31:0] fwd_rt;

    // Decode the ALU opcode in ID so EX only sees a 4-bit control
    always_comb begin
        alu_ctrl_d = ALU_ADD;
        case (id_alu_op)
            2'b00: alu_ctrl_d = ALU_ADD;
            2'b01: alu_ctrl_d = ALU_SUB;
            2'b11: alu_ctrl_d = ALU_OR;
            default: begin
                case (id_funct)
                    FN_ADD:  alu_ctrl_d = ALU_ADD;
                    FN_SUB:  alu_ctrl_d = ALU_SUB;
                    FN_AND:  alu_ctrl_d = ALU_AND;
                    FN_OR:   alu_ctrl_d = ALU_OR;
                    FN_NOR:  alu_ctrl_d = ALU_NOR;
                    FN_SLT:  alu_ctrl_d = ALU_SLT;
                    FN_SLL:  alu_ctrl_d = ALU_SLL;
                    default: alu_ctrl_d = ALU_ADD;
                endcase
            end
        endcase
    end

    assign dest_d = id_reg_dst ? id_rd : id_rt;

    // ID/EX register: reset and flush load a bubble, stall holds, otherwise capture
    always_ff @(posedge clk) begin
        if (!rst_n || flush || (!stall && !id_valid)) begin
            valid_q      <= 1'b0;
            rs_q         <= 5'd0;
            rt_q         <= 5'd0;
            rs_data_q    <= 32'd0;
            rt_data_q    <= 32'd0;
            imm_q        <= 32'd0;
            shamt_q      <= 5'd0;
            alu_ctrl_q   <= ALU_ADD;
            alu_src_q    <= 1'b0;
            dest_q       <= 5'd0;
            reg_write_q  <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_to_reg_q <= 1'b0;
        end else if (!stall) begin
            valid_q      <= 1'b1;
            rs_q         <= id_rs;
            rt_q         <= id_rt;
            rs_data_q    <= id_rs_data;
            rt_data_q    <= id_rt_data;
            imm_q        <= id_imm;
            shamt_q      <= id_shamt;
            alu_ctrl_q   <= alu_ctrl_d;
            alu_src_q    <= id_alu_src;
            dest_q       <= dest_d;
            reg_write_q  <= id_reg_write;
            mem_read_q   <= id_mem_read;
            mem_write_q  <= id_mem_write;
            mem_to_reg_q <= id_mem_to_reg;
        end
    end

    // Operand forwarding: the younger EX/MEM result beats MEM/WB; r0 is never forwarded
    always_comb begin
        fwd_rs = rs_data_q;
        fwd_rt = rt_data_q;
        if (FWD_EN != 0) begin
            if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rs_q)) begin
                fwd_rs = exmem_result;
            end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rs_q)) begin
                fwd_rs = memwb_result;
            end
            if (exmem_reg_write && (exmem_rd != 5'd0) && (exmem_rd == rt_q)) begin
                fwd_rt = exmem_result;
            end else if (memwb_reg_write && (memwb_rd != 5'd0) && (memwb_rd == rt_q)) begin
                fwd_rt = memwb_result;
            end
        end
    end

    // Load-use detection against the instruction currently in ID
    always_comb begin
        hazard_stall = valid_q && mem_read_q && (dest_q != 5'd0) &&
                       ((dest_q == id_rs) || (dest_q == id_rt));
    end

    assign alu_a         = fwd_rs;
    assign alu_b         = alu_src_q ? imm_q : fwd_rt;
    assign alu_control   = alu_ctrl_q;
    assign alu_shamt     = shamt_q;
    assign ex_valid      = valid_q;
    assign ex_dest       = dest_q;
    assign ex_store_data = fwd_rt;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign ex_mem_to_reg = mem_to_reg_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - scoreboard bench for ex_operand_stage
module tb_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, id_valid;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
    logic [5:0]  id_funct;
    logic [1:0]  id_alu_op;
    logic        id_alu_src, id_reg_dst, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        exmem_reg_write, memwb_reg_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic [31:0] exmem_result, memwb_result;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_control;
    logic [4:0]  alu_shamt, ex_dest;
    logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, hazard_stall;

    ex_operand_stage #(.FWD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
        .id_funct(id_funct), .id_alu_op(id_alu_op),
        .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_shamt(alu_shamt),
        .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_store_data(ex_store_data),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_mem_to_reg(ex_mem_to_reg), .hazard_stall(hazard_stall)
    );

    always #5 clk = ~clk;

    // The instruction the model believes sits in EX, kept as raw ID fields
    typedef struct {
        bit        valid;
        bit [4:0]  rs, rt, rd, shamt;
        bit [31:0] rs_data, rt_data, imm;
        bit [5:0]  funct;
        bit [1:0]  alu_op;
        bit        alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
    } instr_t;

    typedef struct {
        int        cyc;
        bit [31:0] alu_a, alu_b, store;
        bit [3:0]  ctrl;
        bit [4:0]  shamt, dest;
        bit        valid, reg_write, mem_read, mem_write, mem_to_reg, hazard;
    } exp_t;

    instr_t m;
    exp_t   sb[$];
    int     tests = 0;
    int     fails = 0;
    int     cyc = 0;

    function automatic instr_t bubble();
        instr_t b;
        b = '{default: 0};
        return b;
    endfunction

    function automatic bit [3:0] alu_code(bit [1:0] op, bit [5:0] fn);
        if (op == 2'd0) return 4'd2;
        if (op == 2'd1) return 4'd6;
        if (op == 2'd3) return 4'd1;
        if (fn == 6'd32) return 4'd2;
        if (fn == 6'd34) return 4'd6;
        if (fn == 6'd36) return 4'd0;
        if (fn == 6'd37) return 4'd1;
        if (fn == 6'd39) return 4'd12;
        if (fn == 6'd42) return 4'd7;
        if (fn == 6'd0)  return 4'd3;
        return 4'd2;
    endfunction

    function automatic bit [31:0] operand(bit [4:0] idx, bit [31:0] raw);
        if (idx == 0) return raw;
        if (exmem_reg_write && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd == idx) return memwb_result;
        return raw;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        bit [4:0] d;
        d = m.valid ? (m.reg_dst ? m.rd : m.rt) : 5'd0;
        e.cyc        = cyc;
        e.valid      = m.valid;
        e.ctrl       = m.valid ? alu_code(m.alu_op, m.funct) : 4'd2;
        e.alu_a      = operand(m.rs, m.rs_data);
        e.store      = operand(m.rt, m.rt_data);
        e.alu_b      = m.alu_src ? m.imm : e.store;
        e.shamt      = m.shamt;
        e.dest       = d;
        e.reg_write  = m.reg_write;
        e.mem_read   = m.mem_read;
        e.mem_write  = m.mem_write;
        e.mem_to_reg = m.mem_to_reg;
        e.hazard     = m.valid && m.mem_read && d != 0 && (d == id_rs || d == id_rt);
        return e;
    endfunction

    task automatic update_model();
        if (!rst_n || flush) m = bubble();
        else if (stall) m = m;
        else if (!id_valid) m = bubble();
        else begin
            m.valid = 1;
            m.rs = id_rs; m.rt = id_rt; m.rd = id_rd; m.shamt = id_shamt;
            m.rs_data = id_rs_data; m.rt_data = id_rt_data; m.imm = id_imm;
            m.funct = id_funct; m.alu_op = id_alu_op;
            m.alu_src = id_alu_src; m.reg_dst = id_reg_dst; m.reg_write = id_reg_write;
            m.mem_read = id_mem_read; m.mem_write = id_mem_write; m.mem_to_reg = id_mem_to_reg;
        end
    endtask

    // Called just after a rising edge: queue this cycle's expectation, then advance
    task automatic step();
        sb.push_back(expect_now());
        @(posedge clk);
        update_model();
        cyc++;
        #1;
    endtask

    task automatic rand_id();
        bit [5:0] fns [8];
        fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd0, 6'd17};
        id_valid = ($urandom_range(0, 9) != 0);
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_rs = 5'($urandom_range(0, 7)); id_rt = 5'($urandom_range(0, 7));
        id_rd = 5'($urandom_range(0, 7)); id_shamt = 5'($urandom);
        id_alu_op = 2'($urandom);
        id_funct = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 7)];
        id_alu_src = 1'($urandom); id_reg_dst = 1'($urandom); id_reg_write = 1'($urandom);
        id_mem_read = 1'($urandom); id_mem_write = 1'($urandom); id_mem_to_reg = 1'($urandom);
    endtask

    task automatic rand_fwd();
        exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7)); exmem_result = $urandom;
        memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7)); memwb_result = $urandom;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; id_valid = 0;
        id_rs_data = 0; id_rt_data = 0; id_imm = 0;
        id_rs = 0; id_rt = 0; id_rd = 0; id_shamt = 0; id_funct = 0; id_alu_op = 0;
        id_alu_src = 0; id_reg_dst = 0; id_reg_write = 0;
        id_mem_read = 0; id_mem_write = 0; id_mem_to_reg = 0;
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    task automatic chk(string name, int c, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, c, act, exp);
        end
    endtask

    // Monitor: compare DUT outputs with the oldest queued expectation mid-cycle
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("alu_a", e.cyc, alu_a, e.alu_a);
            chk("alu_b", e.cyc, alu_b, e.alu_b);
            chk("alu_control", e.cyc, 32'(alu_control), 32'(e.ctrl));
            chk("alu_shamt", e.cyc, 32'(alu_shamt), 32'(e.shamt));
            chk("ex_valid", e.cyc, 32'(ex_valid), 32'(e.valid));
            chk("ex_dest", e.cyc, 32'(ex_dest), 32'(e.dest));
            chk("ex_store_data", e.cyc, ex_store_data, e.store);
            chk("ex_reg_write", e.cyc, 32'(ex_reg_write), 32'(e.reg_write));
            chk("ex_mem_read", e.cyc, 32'(ex_mem_read), 32'(e.mem_read));
            chk("ex_mem_write", e.cyc, 32'(ex_mem_write), 32'(e.mem_write));
            chk("ex_mem_to_reg", e.cyc, 32'(ex_mem_to_reg), 32'(e.mem_to_reg));
            chk("hazard_stall", e.cyc, 32'(hazard_stall), 32'(e.hazard));
        end
    end

    initial begin
        clear_inputs();
        rst_n = 0;
        m = bubble();
        @(posedge clk);
        #1;
        // reset state, with garbage on the ID and forwarding inputs
        rand_id(); rand_fwd(); stall = 1; flush = 0;
        step();
        clear_inputs();
        rst_n = 1;
        step();

        // R-type SLT capture, no forwarding
        id_valid = 1; id_alu_op = 2'b10; id_funct = 6'b101010;
        id_rs = 1; id_rt = 2; id_rs_data = 5; id_rt_data = 9; id_rd = 3; id_reg_dst = 1;
        step();
        id_valid = 0; stall = 1;
        step();

        // double forward on rs=3, then MEM/WB only, then rs=0
        stall = 0; clear_inputs(); id_valid = 1; id_rs = 3; id_rs_data = 32'h11; id_reg_write = 1;
        step();
        stall = 1; id_valid = 0;
        exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
        memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBB;
        step();
        exmem_reg_write = 0;
        step();
        stall = 0; id_valid = 1; id_rs = 0; id_rs_data = 32'h55;
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
        step();
        stall = 1; id_valid = 0;
        step();

        // immediate path with forwarded store data
        clear_inputs(); id_valid = 1; id_alu_src = 1; id_imm = 32'hFFFFFFFC;
        id_rt = 4; id_rt_data = 32'h99; id_mem_write = 1;
        step();
        stall = 1; id_valid = 0; exmem_reg_write = 1; exmem_rd = 4; exmem_result = 32'h10;
        step();

        // load-use detection
        clear_inputs(); id_valid = 1; id_mem_read = 1; id_mem_to_reg = 1; id_reg_write = 1;
        id_rt = 7; id_rs = 2;
        step();
        stall = 1; id_valid = 1; id_mem_read = 0; id_rs = 7; id_rt = 1;
        step();
        id_rs = 8; id_rt = 7;
        step();
        id_rs = 9; id_rt = 10;
        step();
        stall = 0; id_mem_read = 1; id_rt = 0; id_rs = 0;
        step();
        step();

        // stall holds for three cycles while ID changes
        clear_inputs(); rand_id(); id_valid = 1;
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            rand_id(); step();
        end
        // flush overrides stall
        flush = 1;
        step();
        flush = 0; stall = 0; rand_id(); id_valid = 1;
        step();
        // reset overrides a stall
        stall = 1; rst_n = 0;
        step();
        rst_n = 1;
        step();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            rand_id(); rand_fwd();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 9) == 0);
            rst_n = ($urandom_range(0, 29) != 0);
            step();
        end

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
